bsg_axil_to_fifos_tx_buf: RTL

BSG_AXIL_TO_FIFOS_TX_BUF -- requirements
Module: bsg_axil_to_fifos_tx_buf

---
 rtl/bsg_axil_to_fifos_tx_buf.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bsg_axil_to_fifos_tx_buf.sv
// AXI-Lite write slave that pushes 32-bit TDR writes into per-channel circular TX buffers
// and turns ISR writes into one-cycle TC-clear pulses.
module bsg_axil_to_fifos_tx_buf #(
    parameter int          num_fifos_p       = 2,
    parameter int          buf_els_p         = 4,
    parameter logic [31:0] base_addr_p       = 32'h0000_1000,
    parameter int          base_addr_width_p = 8,
    parameter int          tc_bit_p          = 27
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [31:0]                 awaddr_i,
    input  logic                        awvalid_i,
    output logic                        awready_o,

    input  logic [31:0]                 wdata_i,
    input  logic [3:0]                  wstrb_i,
    input  logic                        wvalid_i,
    output logic                        wready_o,

    output logic [1:0]                  bresp_o,
    output logic                        bvalid_o,
    input  logic                        bready_i,

    output logic [num_fifos_p-1:0][31:0] tx_data_o,
    output logic [num_fifos_p-1:0]      tx_v_o,
    input  logic [num_fifos_p-1:0]      tx_ready_i,

    output logic [num_fifos_p-1:0]      clear_isr_tc_o,
    output logic [1:0]                  debug_state_o
);

    localparam int ptr_w_lp = $clog2(buf_els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam int idx_w_lp = 32 - base_addr_width_p;

    localparam logic [1:0] resp_okay_lp   = 2'b00;
    localparam logic [1:0] resp_slverr_lp = 2'b10;
    localparam logic [1:0] resp_decerr_lp = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                   state_q;
    logic                     aw_held_q, w_held_q;
    logic [31:0]              awaddr_q, wdata_q;
    logic [3:0]               wstrb_q;
    logic [1:0]               bresp_q;
    logic [num_fifos_p-1:0]   clear_q;

    logic                     aw_fire, w_fire;
    logic [idx_w_lp-1:0]      idx;
    logic [base_addr_width_p-1:0] offset;
    logic                     addr_ok, is_tdr, is_isr, strb_ok, tc_req;
    logic [num_fifos_p-1:0]   sel, full, push_v;
    logic                     full_sel, push_en;

    // Every channel is valid/ready: a beat transfers on the rising edge where both
    // valid and ready are high; AW/W are only ready in IDLE until their beat is held,
    // and B holds bvalid with a stable bresp until bready is seen.
    assign awready_o      = (state_q == IDLE) && !aw_held_q;
    assign wready_o       = (state_q == IDLE) && !w_held_q;
    assign bvalid_o       = (state_q == RESP);
    assign bresp_o        = bresp_q;
    assign clear_isr_tc_o = clear_q;
    assign debug_state_o  = state_q;

    assign aw_fire = awvalid_i && awready_o;
    assign w_fire  = wvalid_i && wready_o;

    assign idx     = awaddr_q[31:base_addr_width_p] - base_addr_p[31:base_addr_width_p];
    assign offset  = awaddr_q[base_addr_width_p-1:0];
    assign addr_ok = idx < idx_w_lp'(num_fifos_p);
    assign is_tdr  = offset == '0;
    assign is_isr  = offset == base_addr_width_p'(4);
    assign strb_ok = wstrb_q == 4'hF;
    assign tc_req  = wdata_q[tc_bit_p] && wstrb_q[tc_bit_p/8];

    always_comb begin
        sel = '0;
        for (int i = 0; i < num_fifos_p; i++) begin
            sel[i] = addr_ok && (idx == idx_w_lp'(i));
        end
    end

    assign full_sel = |(full & sel);
    assign push_en  = (state_q == EXEC) && addr_ok && is_tdr && strb_ok && !full_sel;
    assign push_v   = push_en ? sel : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= resp_okay_lp;
            clear_q   <= '0;
        end else begin
            clear_q <= '0;
            case (state_q)
                IDLE: begin
                    if (aw_fire) begin
                        aw_held_q <= 1'b1;
                        awaddr_q  <= awaddr_i;
                    end
                    if (w_fire) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= wdata_i;
                        wstrb_q  <= wstrb_i;
                    end
                    if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!addr_ok || !(is_tdr || is_isr)) begin
                        bresp_q <= resp_decerr_lp;
                        state_q <= RESP;
                    end else if (is_isr) begin
                        bresp_q <= resp_okay_lp;
                        if (tc_req) begin
                            clear_q <= sel;
                        end
                        state_q <= RESP;
                    end else if (!strb_ok) begin
                        bresp_q <= resp_slverr_lp;
                        state_q <= RESP;
                    end else if (!full_sel) begin
                        // A full TDR target leaves us parked here until a pop frees a slot.
                        bresp_q <= resp_okay_lp;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (bready_i) begin
                        state_q   <= IDLE;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < num_fifos_p; i++) begin : g_ch
        logic [31:0]         mem_q [buf_els_p];
        logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
        logic [cnt_w_lp-1:0] cnt_q, cnt_d;
        logic                push, pop;

        assign push = push_v[i];
        assign pop  = tx_v_o[i] && tx_ready_i[i];

        assign full[i]      = cnt_q == cnt_w_lp'(buf_els_p);
        assign tx_v_o[i]    = cnt_q != '0;
        assign tx_data_o[i] = mem_q[rd_ptr_q];

        always_comb begin
            cnt_d = cnt_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
                2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Power-of-two depth lets the pointers wrap by natural overflow.
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + ptr_w_lp'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + ptr_w_lp'(1);
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_ptr_q] <= wdata_q;
        end
    end

endmodule
